// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for a shared tri-state data bus.
// Each gnt bit is the data_en of one requester's bus Driver. At most one
// Driver is enabled per cycle, and a dead turnaround gap of TURN_CYCLES
// all-disabled cycles separates successive owners.
//
// Optional feature macro: BUS_ARB_LOCK_EN
//   When defined, a 'lock' input lets the current owner hold the bus past
//   MAX_HOLD; the owner then leaves only by dropping its request.
//
// Handshake: req is level-sensitive and sampled on every rising edge with no
// memory. A requester may drive the bus only while its gnt bit is high.
// gnt, owner and busy are all registered.
module bus_arbiter #(
    parameter int NREQ        = 4,
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
`ifdef BUS_ARB_LOCK_EN
    input  logic                    lock,
`endif
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    localparam int OW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [OW-1:0]   ptr, ptr_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [TW-1:0]   turn_cnt, turn_n;
    logic [NREQ-1:0] gnt_n;
    logic [OW-1:0]   owner_n;
    logic            busy_n;

    logic [OW-1:0]   win_idx;
    logic            win_found;
    logic [OW:0]     cand;
    logic [NREQ-1:0] owner_oh;
    logic [NREQ-1:0] win_oh;
    logic            others_wait;
    logic            hold_limit;
    logic            preempt_ok;
    logic            release_bus;

    // Round-robin scan: first requesting index starting at ptr, wrapping.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (OW + 1)'(k);
            if (cand >= (OW + 1)'(NREQ)) begin
                cand = cand - (OW + 1)'(NREQ);
            end
            if (!win_found && req[cand[OW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[OW-1:0];
            end
        end
    end

    assign owner_oh    = {{(NREQ-1){1'b0}}, 1'b1} << owner;
    assign win_oh      = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    assign others_wait = |(req & ~owner_oh);
    // hold_cnt saturates at MAX_HOLD, so ">=" keeps preemption reachable
    // when a competitor shows up after the owner has already saturated.
    assign hold_limit  = (hold_cnt >= HW'(MAX_HOLD - 1));

`ifdef BUS_ARB_LOCK_EN
    assign preempt_ok = ~lock;
`else
    assign preempt_ok = 1'b1;
`endif

    assign release_bus = ~req[owner] | (others_wait & hold_limit & preempt_ok);

    // Next-state and next-output logic for the IDLE/GRANT/TURN controller.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        turn_n  = turn_cnt;
        gnt_n   = gnt;
        owner_n = owner;
        busy_n  = busy;

        case (state)
            IDLE: begin
                gnt_n = '0;
                if (win_found) begin
                    state_n = GRANT;
                    gnt_n   = win_oh;
                    owner_n = win_idx;
                    hold_n  = '0;
                end
            end

            GRANT: begin
                if (release_bus) begin
                    // Leave through TURN; the current owner ranks last next.
                    state_n = TURN;
                    gnt_n   = '0;
                    turn_n  = TW'(TURN_CYCLES - 1);
                    if (owner == OW'(NREQ - 1)) begin
                        ptr_n = '0;
                    end else begin
                        ptr_n = owner + 1'b1;
                    end
                end else begin
                    gnt_n = owner_oh;
                    if (hold_cnt < HW'(MAX_HOLD)) begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
            end

            TURN: begin
                gnt_n = '0;
                if (turn_cnt == '0) begin
                    if (win_found) begin
                        state_n = GRANT;
                        gnt_n   = win_oh;
                        owner_n = win_idx;
                        hold_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    turn_n = turn_cnt - 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and registered outputs; reset drops gnt immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            turn_cnt <= turn_n;
            gnt      <= gnt_n;
            owner    <= owner_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random stimulus for bus_arbiter, checked
// against a cycle-level model of owner/hold/gap bookkeeping.
module tb_bus_arbiter;
    localparam int NREQ        = 4;
    localparam int MAX_HOLD    = 8;
    localparam int TURN_CYCLES = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
`ifdef BUS_ARB_LOCK_EN
    logic       lock = 1'b0;
`endif
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Model: who owns the bus, how many cycles it has held, dead-gap remaining.
    int m_active = 0;
    int m_own    = 0;
    int m_held   = 0;
    int m_gap    = 0;
    int m_ptr    = 0;

    bus_arbiter #(
        .NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .TURN_CYCLES(TURN_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
`ifdef BUS_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt),
        .owner(owner),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int winner(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_own = 0; m_held = 0; m_gap = 0; m_ptr = 0;
    endtask

    task automatic model_grant();
        int w;
        w = winner(req, m_ptr);
        if (w >= 0) begin
            m_active = 1; m_own = w; m_held = 0;
        end
    endtask

    task automatic model_edge();
        logic others;
        logic locked;
        others = (req & ~(4'b0001 << m_own)) != 4'b0000;
        locked = 1'b0;
`ifdef BUS_ARB_LOCK_EN
        locked = lock;
`endif
        if (m_active != 0) begin
            m_held++;
            if (!req[m_own] || (others && m_held >= MAX_HOLD && !locked)) begin
                m_active = 0;
                m_gap    = TURN_CYCLES;
                m_ptr    = (m_own + 1) % NREQ;
            end
        end else if (m_gap > 0) begin
            if (m_gap == 1) begin
                m_gap = 0;
                model_grant();
            end else begin
                m_gap--;
            end
        end else begin
            model_grant();
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] e_gnt;
        e_gnt = (m_active != 0) ? (4'b0001 << m_own) : 4'b0000;
        check({tag, "_gnt"},   16'(gnt),   16'(e_gnt));
        check({tag, "_owner"}, 16'(owner), 16'(m_own));
        check({tag, "_busy"},  16'(busy),  16'((m_active != 0) || (m_gap > 0)));
        check({tag, "_onehot"}, 16'($onehot0(gnt)), 16'd1);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_model("rst_async");
        @(posedge clk);
        #1;
        check_model("rst_held");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset with all requesting, first grant one edge after release
        req = 4'b1111;
        apply_reset();
        check("t1_gnt0", 16'(gnt), 16'h0);
        step("t1_first");
        check("t1_gnt_first", 16'(gnt), 16'h1);

        // 3: all requesting -> 8 grant cycles, one dead cycle, rotate and wrap
        for (int i = 0; i < 37; i++) step("t3_rr");
        check("t3_wrap", 16'(gnt), 16'h1);

        // 2: single requester held for a few edges then dropped
        req = 4'b0000;
        apply_reset();
        req = 4'b0100;
        for (int i = 0; i < 5; i++) step("t2_hold");
        check("t2_gnt", 16'(gnt), 16'h4);
        req = 4'b0000;
        step("t2_turn");
        check("t2_turn_gnt", 16'(gnt), 16'h0);
        check("t2_turn_busy", 16'(busy), 16'h1);
        step("t2_idle");
        check("t2_idle_busy", 16'(busy), 16'h0);

        // 4: owner 3 releases while requester 0 waits
        req = 4'b1000;
        step("t4_own3");
        step("t4_own3b");
        check("t4_owner3", 16'(owner), 16'h3);
        req = 4'b0001;
        step("t4_dead");
        check("t4_dead_gnt", 16'(gnt), 16'h0);
        step("t4_new");
        check("t4_new_gnt", 16'(gnt), 16'h1);
        check("t4_new_owner", 16'(owner), 16'h0);

        // 5: reset pulse mid-grant, gnt drops before the next edge
        req = 4'b0000;
        apply_reset();
        req = 4'b0010;
        step("t5_g1");
        req = 4'b0011;
        step("t5_g2");
        check("t5_pre_gnt", 16'(gnt), 16'h2);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("t5_async_gnt", 16'(gnt), 16'h0);
        check_model("t5_async");
        #1;
        rst = 1'b0;
        step("t5_post");
        check("t5_post_gnt", 16'(gnt), 16'h1);

        // 6: two requesters, owner 0; lock holds the bus if available
        req = 4'b0000;
        apply_reset();
        req = 4'b0011;
`ifdef BUS_ARB_LOCK_EN
        lock = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step("t6_lock");
            check("t6_lock_gnt", 16'(gnt), 16'h1);
        end
        lock = 1'b0;
        step("t6_unlock_turn");
        check("t6_turn_gnt", 16'(gnt), 16'h0);
        step("t6_next");
        check("t6_next_gnt", 16'(gnt), 16'h2);
`else
        for (int i = 0; i < 8; i++) begin
            step("t6_hold");
            check("t6_hold_gnt", 16'(gnt), 16'h1);
        end
        step("t6_preempt");
        check("t6_preempt_gnt", 16'(gnt), 16'h0);
        step("t6_next");
        check("t6_next_gnt", 16'(gnt), 16'h2);
`endif

        // Random: sticky request patterns with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
`ifdef BUS_ARB_LOCK_EN
            if ($urandom_range(0, 7) == 0) lock = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 149) == 0) apply_reset();
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
